kbd_decode: RTL

KBD_DECODE -- requirements
Module: kbd_decode

---
 rtl/kbd_decode.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/kbd_decode.sv
// PS/2 set-2 scan code decoder with modifier tracking and an ASCII output FIFO.
// First-word-fall-through queue; sticky overflow flag for dropped characters.
module kbd_decode #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] scan_in,
    input  logic       scan_vld,
    input  logic       rd,
    input  logic       clr_ovf,
    output logic [7:0] ascii_out,
    output logic       rdy,
    output logic       caps_led,
    output logic       ovf
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        BRK,
        EXT,
        EXT_BRK
    } state_t;

    state_t          state;
    logic            lshift;
    logic            rshift;
    logic            caps;
    logic            caps_held;
    logic            ovf_q;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wptr;
    logic [AW-1:0]   rptr;
    logic [AW:0]     count;

    logic            push;
    logic [7:0]      push_ch;
    logic [8:0]      xl;
    logic            empty;
    logic            full;
    logic            do_pop;
    logic            do_push;
    logic            drop;
    logic            discard;

    // Returns {hit, ascii}; hit=0 when the make code has no printable mapping.
    function automatic logic [8:0] xlate(
        input logic [7:0] code,
        input logic       sh,
        input logic       cp
    );
        logic [4:0] li;
        logic       lhit;
        logic [3:0] di;
        logic       dhit;
        logic [7:0] dsh;
        logic [8:0] r;
        li   = '0;
        lhit = 1'b1;
        di   = '0;
        dhit = 1'b1;
        dsh  = '0;
        r    = '0;
        case (code)
            8'h1C: li = 5'd0;
            8'h32: li = 5'd1;
            8'h21: li = 5'd2;
            8'h23: li = 5'd3;
            8'h24: li = 5'd4;
            8'h2B: li = 5'd5;
            8'h34: li = 5'd6;
            8'h33: li = 5'd7;
            8'h43: li = 5'd8;
            8'h3B: li = 5'd9;
            8'h42: li = 5'd10;
            8'h4B: li = 5'd11;
            8'h3A: li = 5'd12;
            8'h31: li = 5'd13;
            8'h44: li = 5'd14;
            8'h4D: li = 5'd15;
            8'h15: li = 5'd16;
            8'h2D: li = 5'd17;
            8'h1B: li = 5'd18;
            8'h2C: li = 5'd19;
            8'h3C: li = 5'd20;
            8'h2A: li = 5'd21;
            8'h1D: li = 5'd22;
            8'h22: li = 5'd23;
            8'h35: li = 5'd24;
            8'h1A: li = 5'd25;
            default: lhit = 1'b0;
        endcase
        case (code)
            8'h45: di = 4'd0;
            8'h16: di = 4'd1;
            8'h1E: di = 4'd2;
            8'h26: di = 4'd3;
            8'h25: di = 4'd4;
            8'h2E: di = 4'd5;
            8'h36: di = 4'd6;
            8'h3D: di = 4'd7;
            8'h3E: di = 4'd8;
            8'h46: di = 4'd9;
            default: dhit = 1'b0;
        endcase
        case (di)
            4'd0:    dsh = 8'h29;
            4'd1:    dsh = 8'h21;
            4'd2:    dsh = 8'h40;
            4'd3:    dsh = 8'h23;
            4'd4:    dsh = 8'h24;
            4'd5:    dsh = 8'h25;
            4'd6:    dsh = 8'h5E;
            4'd7:    dsh = 8'h26;
            4'd8:    dsh = 8'h2A;
            default: dsh = 8'h28;
        endcase
        if (lhit) begin
            r = {1'b1, ((sh ^ cp) ? 8'h41 : 8'h61) + {3'b000, li}};
        end else if (dhit) begin
            r = {1'b1, sh ? dsh : (8'h30 + {4'b0000, di})};
        end else begin
            case (code)
                8'h29:   r = 9'h120;
                8'h5A:   r = 9'h10D;
                8'h66:   r = 9'h108;
                8'h0D:   r = 9'h109;
                default: r = 9'h000;
            endcase
        end
        return r;
    endfunction

    always_comb begin
        xl      = xlate(scan_in, lshift | rshift, caps);
        push    = 1'b0;
        push_ch = 8'h00;
        discard = 1'b0;
        case (scan_in)
            8'h00, 8'hAA, 8'hFA,
            8'hFC, 8'hFE, 8'hFF: discard = 1'b1;
            default:             discard = 1'b0;
        endcase
        if (scan_vld && state == IDLE && xl[8]) begin
            push    = 1'b1;
            push_ch = xl[7:0];
        end else if (scan_vld && state == EXT && scan_in == 8'h5A) begin
            push    = 1'b1;
            push_ch = 8'h0D;
        end
    end

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(FIFO_DEPTH));
    assign do_pop  = rd && !empty;
    // A full queue still accepts a push when the head leaves on the same edge.
    assign do_push = push && (!full || do_pop);
    assign drop    = push && full && !do_pop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            lshift    <= 1'b0;
            rshift    <= 1'b0;
            caps      <= 1'b0;
            caps_held <= 1'b0;
        end else if (scan_vld) begin
            if (discard) begin
                state <= IDLE;
            end else if (scan_in == 8'hE0) begin
                state <= EXT;
            end else if (scan_in == 8'hF0) begin
                if (state == EXT || state == EXT_BRK) state <= EXT_BRK;
                else                                  state <= BRK;
            end else begin
                case (state)
                    IDLE: begin
                        if (scan_in == 8'h12) lshift <= 1'b1;
                        if (scan_in == 8'h59) rshift <= 1'b1;
                        if (scan_in == 8'h58) begin
                            if (!caps_held) caps <= ~caps;
                            caps_held <= 1'b1;
                        end
                    end
                    BRK: begin
                        if (scan_in == 8'h12) lshift    <= 1'b0;
                        if (scan_in == 8'h59) rshift    <= 1'b0;
                        if (scan_in == 8'h58) caps_held <= 1'b0;
                    end
                    default: ;
                endcase
                state <= IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            ovf_q <= 1'b0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            if (do_push && !do_pop)      count <= count + (AW+1)'(1);
            else if (do_pop && !do_push) count <= count - (AW+1)'(1);
            if (drop)         ovf_q <= 1'b1;
            else if (clr_ovf) ovf_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= push_ch;
    end

    assign ascii_out = empty ? 8'h00 : mem[rptr];
    assign rdy       = !empty;
    assign caps_led  = caps;
    assign ovf       = ovf_q;

endmodule
